// File: rtl/ov_cfg_seq.sv
// ov_cfg_seq - camera register-initialisation sequencer.
// After a start pulse and a power-up wait, walks a synchronous register ROM
// of {reg_addr, reg_val} entries and issues one SCCB write per entry.
// Entries with reg_addr 8'hFF are delays of reg_val*DLY_UNIT cycles.
// Optional readback verification of every write: define OV_CFG_READBACK_EN.
//
// Handshake: there is no valid/ready pair on this block. sccb_wr_en and
// sccb_rd_en are single-cycle request pulses (never high together);
// sccb_done and sccb_rdata_vld are single-cycle completion pulses that are
// only looked at while the matching *_WAIT state is active, otherwise ignored.
module ov_cfg_seq #(
  parameter int         PWR_DLY  = 20000,
  parameter int         DLY_UNIT = 50000,
  parameter logic [7:0] REG_NUM  = 8'd200,
  parameter int         TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sccb_wr_en,
  output logic        sccb_rd_en,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_done,
  input  logic [7:0]  sccb_rdata,
  input  logic        sccb_rdata_vld,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [3:0]  dbg_state_o
);

  // Last count value of each wait; the request cycle counts as the first
  // cycle of a transaction timeout.
  localparam logic [31:0] PWR_LAST   = (PWR_DLY > 1) ? 32'(PWR_DLY - 1) : 32'd0;
  localparam logic [31:0] TO_LAST    = (TIMEOUT > 1) ? 32'(TIMEOUT - 1) : 32'd1;
  localparam logic [31:0] DLY_UNIT_W = 32'(DLY_UNIT);
  localparam logic [7:0]  LAST_IDX   = REG_NUM - 8'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_WR_REQ, S_WR_WAIT,
    S_RD_REQ, S_RD_WAIT, S_DLY, S_NEXT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

`ifdef OV_CFG_READBACK_EN
  localparam logic [7:0] SOFT_RST_REG = 8'h12;  // readback would race the sensor reset
  logic retry_q, retry_d;
`endif

  // State and datapath registers; reset aborts any pass in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef OV_CFG_READBACK_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef OV_CFG_READBACK_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // Next-state and datapath updates for the configuration walk.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef OV_CFG_READBACK_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_PWR_WAIT;
          cnt_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q >= PWR_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FETCH: state_d = S_DECODE;  // ROM read latency
      S_DECODE: begin
        if (rom_data[15:8] == 8'hFF) begin
          cnt_d   = 32'(rom_data[7:0]) * DLY_UNIT_W;
          state_d = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DLY;
        end else begin
          addr_d  = rom_data[15:8];
          wdata_d = rom_data[7:0];
          state_d = S_WR_REQ;
`ifdef OV_CFG_READBACK_EN
          retry_d = 1'b0;
`endif
        end
      end
      S_WR_REQ: begin
        cnt_d   = 32'd1;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (sccb_done) begin
`ifdef OV_CFG_READBACK_EN
          state_d = (addr_q == SOFT_RST_REG) ? S_NEXT : S_RD_REQ;
`else
          state_d = S_NEXT;
`endif
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef OV_CFG_READBACK_EN
      S_RD_REQ: begin
        cnt_d   = 32'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (sccb_rdata_vld) begin
          if (sccb_rdata == wdata_q) begin
            state_d = S_NEXT;
          end else if (!retry_q) begin
            retry_d = 1'b1;
            state_d = S_WR_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      S_DLY: begin
        if (cnt_q <= 32'd1) state_d = S_NEXT;
        else                cnt_d   = cnt_q - 32'd1;
      end
      S_NEXT: begin
        if (rom_addr_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = rom_addr_q + 8'd1;
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = ~err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr    = rom_addr_q;
  assign sccb_wr_en  = (state_q == S_WR_REQ);
  assign sccb_addr   = addr_q;
  assign sccb_wdata  = wdata_q;
  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign dbg_state_o = state_q;

`ifdef OV_CFG_READBACK_EN
  assign sccb_rd_en = (state_q == S_RD_REQ);
`else
  // Readback path absent: read request tied off, read inputs unused.
  logic unused_rd;
  assign unused_rd  = ^{sccb_rdata, sccb_rdata_vld};
  assign sccb_rd_en = 1'b0;
`endif

endmodule
